// File: rtl/sobel_win_ctrl_pkg.sv
// Shared definitions for the Sobel window sequencer: default pixel width,
// FSM state encoding and 3x3 window element indices (index = 3*row + col).
package sobel_pkg;

  localparam int SOBEL_DW = 12;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_FILL = 2'd1;
  localparam logic [1:0] ST_RUN  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  localparam int unsigned WIN_TL = 0;
  localparam int unsigned WIN_TM = 1;
  localparam int unsigned WIN_TR = 2;
  localparam int unsigned WIN_ML = 3;
  localparam int unsigned WIN_MM = 4;
  localparam int unsigned WIN_MR = 5;
  localparam int unsigned WIN_BL = 6;
  localparam int unsigned WIN_BM = 7;
  localparam int unsigned WIN_BR = 8;

endpackage

// File: rtl/sobel_win_ctrl_if.sv
// Pixel-stream input and 3x3 window output bundle of the Sobel sequencer.
// master = pixel source / window consumer, slave = sobel_win_ctrl.
interface sobel_win_ctrl_if
  import sobel_pkg::*;
#(
  parameter int DW = SOBEL_DW
);
  logic [DW-1:0]   i_pix_data;
  logic            i_pix_valid;
  logic            i_pix_sof;
  logic [9*DW-1:0] o_win_data;
  logic            o_win_valid;

  modport master (
    output i_pix_data, i_pix_valid, i_pix_sof,
    input  o_win_data, o_win_valid
  );

  modport slave (
    input  i_pix_data, i_pix_valid, i_pix_sof,
    output o_win_data, o_win_valid
  );
endinterface

// File: rtl/sobel_win_ctrl_line_buf.sv
// One line of pixel storage: single-port RAM, combinational read of the
// addressed word, write at the clock edge (read-before-write). Not reset.
module sobel_line_buf
  import sobel_pkg::*;
#(
  parameter int DW    = SOBEL_DW,
  parameter int DEPTH = 640,
  parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          i_clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_addr,
  input  logic [DW-1:0] i_wdata,
  output logic [DW-1:0] o_rdata
);

  logic [DW-1:0] r_mem [DEPTH];

  // Store the new word; the old word stays on o_rdata until this edge
  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_addr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/sobel_win_ctrl.sv
// Sobel window sequencer: two line buffers plus a 3x3 register window turn
// the raster stream into one window per interior pixel; owns frame state and
// the edge-threshold shadow register.
// Optional feature macro: SOBEL_WIN_STATS_EN (adds o_win_count).
module sobel_win_ctrl
  import sobel_pkg::*;
#(
  parameter int          DW         = SOBEL_DW,
  parameter int          IMG_W      = 640,
  parameter int          IMG_H      = 480,
  parameter logic [11:0] THRESH_RST = 12'd400
) (
  input  logic              i_clk,
  input  logic              i_rstn,
  sobel_win_ctrl_if.slave   bus,
  input  logic [11:0]       i_cfg_thresh,
  input  logic              i_cfg_wr,
  output logic [11:0]       o_sobel_thresh,
  output logic              o_busy,
  output logic              o_frame_done,
  output logic              o_err_overrun
`ifdef SOBEL_WIN_STATS_EN
  ,
  output logic [31:0]       o_win_count
`endif
);

  localparam int XW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int YW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(IMG_H - 1);

  logic [1:0]      r_state;
  logic [1:0]      w_state_next;
  logic [XW-1:0]   r_x;
  logic [YW-1:0]   r_y;
  logic [DW-1:0]   r_win [9];
  logic [DW-1:0]   w_win_next [9];
  logic [9*DW-1:0] w_win_flat;
  logic [9*DW-1:0] r_win_data;
  logic            r_win_valid;
  logic            r_err;
  logic [11:0]     r_thresh;
  logic [11:0]     r_pend_val;
  logic            r_pend;

  logic            w_in_frame;
  logic            w_acc;
  logic            w_restart;
  logic            w_overrun;
  logic            w_issue;
  logic            w_apply;
  logic [XW-1:0]   w_px;
  logic [YW-1:0]   w_py;
  logic            w_x_last;
  logic            w_y_last;
  logic [DW-1:0]   w_lb1_rd;
  logic [DW-1:0]   w_lb2_rd;

  // Outside a frame only a sof pixel is taken; a sof inside a frame restarts it
  assign w_in_frame = (r_state == ST_FILL) || (r_state == ST_RUN);
  assign w_acc      = bus.i_pix_valid && (w_in_frame || bus.i_pix_sof);
  assign w_restart  = w_acc && bus.i_pix_sof;
  assign w_overrun  = w_restart && w_in_frame;
  assign w_px       = w_restart ? '0 : r_x;
  assign w_py       = w_restart ? '0 : r_y;
  assign w_x_last   = (w_px == X_LAST);
  assign w_y_last   = (w_py == Y_LAST);
  assign w_issue    = w_acc && (w_px >= XW'(2)) && (w_py >= YW'(2));
  assign w_apply    = r_pend && ((r_state == ST_IDLE) || (r_state == ST_DONE));

  sobel_line_buf #(.DW(DW), .DEPTH(IMG_W), .AW(XW)) u_lb1 (
    .i_clk   (i_clk),
    .i_we    (w_acc),
    .i_addr  (w_px),
    .i_wdata (bus.i_pix_data),
    .o_rdata (w_lb1_rd)
  );

  sobel_line_buf #(.DW(DW), .DEPTH(IMG_W), .AW(XW)) u_lb2 (
    .i_clk   (i_clk),
    .i_we    (w_acc),
    .i_addr  (w_px),
    .i_wdata (w_lb1_rd),
    .o_rdata (w_lb2_rd)
  );

  // Window after shifting in the column {lb2[x], lb1[x], pix} as col 2
  always_comb begin
    for (int unsigned r = 0; r < 3; r++) begin
      w_win_next[3*r]     = r_win[3*r + 1];
      w_win_next[3*r + 1] = r_win[3*r + 2];
      w_win_next[3*r + 2] = r_win[3*r + 2];
    end
    w_win_next[WIN_TR] = w_lb2_rd;
    w_win_next[WIN_MR] = w_lb1_rd;
    w_win_next[WIN_BR] = bus.i_pix_data;
    w_win_flat = '0;
    for (int unsigned i = 0; i < 9; i++) begin
      w_win_flat[i*DW +: DW] = w_win_next[i];
    end
  end

  // Next FSM state from the accepted pixel's position
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (w_restart) w_state_next = ST_FILL;
      ST_FILL: begin
        if (w_restart)                                        w_state_next = ST_FILL;
        else if (w_acc && w_x_last && (w_py == YW'(1)))       w_state_next = ST_RUN;
      end
      ST_RUN: begin
        if (w_restart)                                        w_state_next = ST_FILL;
        else if (w_acc && w_x_last && w_y_last)               w_state_next = ST_DONE;
      end
      default: w_state_next = w_restart ? ST_FILL : ST_IDLE;
    endcase
  end

  // Frame state and raster position of the next expected pixel
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_state <= ST_IDLE;
      r_x     <= '0;
      r_y     <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_acc) begin
        if (w_x_last) begin
          r_x <= '0;
          r_y <= w_y_last ? '0 : w_py + YW'(1);
        end else begin
          r_x <= w_px + XW'(1);
          r_y <= w_py;
        end
      end
    end
  end

  // 3x3 shift window and the held output copy for issued windows
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      for (int unsigned i = 0; i < 9; i++) r_win[i] <= '0;
      r_win_data  <= '0;
      r_win_valid <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      if (w_acc) begin
        for (int unsigned i = 0; i < 9; i++) r_win[i] <= w_win_next[i];
      end
      if (w_issue) r_win_data <= w_win_flat;
      r_win_valid <= w_issue;
      r_err       <= w_overrun;
    end
  end

  // Threshold shadow: a write landing with an apply stays pending for the next boundary
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_thresh   <= THRESH_RST;
      r_pend_val <= '0;
      r_pend     <= 1'b0;
    end else begin
      if (w_apply) r_thresh <= r_pend_val;
      if (i_cfg_wr) begin
        r_pend_val <= i_cfg_thresh;
        r_pend     <= 1'b1;
      end else if (w_apply) begin
        r_pend     <= 1'b0;
      end
    end
  end

`ifdef SOBEL_WIN_STATS_EN
  logic [31:0] r_win_count;

  // Windows issued in the current frame, held after DONE until the next sof
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn)        r_win_count <= '0;
    else if (w_restart) r_win_count <= '0;
    else if (w_issue)   r_win_count <= r_win_count + 32'd1;
  end

  assign o_win_count = r_win_count;
`endif

  assign bus.o_win_data  = r_win_data;
  assign bus.o_win_valid = r_win_valid;
  assign o_sobel_thresh  = r_thresh;
  assign o_busy          = (r_state != ST_IDLE);
  assign o_frame_done    = (r_state == ST_DONE);
  assign o_err_overrun   = r_err;

endmodule

// File: tb/tb_sobel_win_ctrl.sv
// Scoreboard bench for sobel_win_ctrl (IMG_W=5, IMG_H=4): the stimulus side
// keeps an image model of the current frame and queues expected windows; a
// negedge monitor pops and compares every presented window.
module tb_sobel_win_ctrl;
  import sobel_pkg::*;

  localparam int          DW = 12;
  localparam int          W  = 5;
  localparam int          H  = 4;
  localparam logic [11:0] TR = 12'd400;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [11:0] cfg_thresh;
  logic        cfg_wr;
  logic [11:0] thresh;
  logic        busy;
  logic        fdone;
  logic        ovr;
`ifdef SOBEL_WIN_STATS_EN
  logic [31:0] win_count;
`endif

  always #5 clk = ~clk;

  sobel_win_ctrl_if #(.DW(DW)) bus ();

  sobel_win_ctrl #(
    .DW(DW), .IMG_W(W), .IMG_H(H), .THRESH_RST(TR)
  ) dut (
    .i_clk          (clk),
    .i_rstn         (rstn),
    .bus            (bus),
    .i_cfg_thresh   (cfg_thresh),
    .i_cfg_wr       (cfg_wr),
    .o_sobel_thresh (thresh),
    .o_busy         (busy),
    .o_frame_done   (fdone),
    .o_err_overrun  (ovr)
`ifdef SOBEL_WIN_STATS_EN
    ,
    .o_win_count    (win_count)
`endif
  );

  int errors = 0;
  int checks = 0;
  logic [9*DW-1:0] exp_q[$];
  logic [DW-1:0]   img [H][W];
  int mx = 0, my = 0;
  bit mactive = 0;
  int exp_done = 0, exp_ovr = 0, seen_done = 0, seen_ovr = 0;
  bit watch_thresh = 0, early_thresh = 0;

  task automatic chk(input string nm, input longint unsigned act, input longint unsigned exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Reference model: frame position from the stream, windows from the image array
  task automatic model_pixel(input bit sof, input logic [DW-1:0] val);
    logic [9*DW-1:0] w;
    if (sof) begin
      if (mactive) exp_ovr++;
      mx = 0; my = 0; mactive = 1;
    end else if (!mactive) begin
      return;
    end
    img[my][mx] = val;
    if (mx >= 2 && my >= 2) begin
      w = '0;
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++)
          w[(3*r+c)*DW +: DW] = img[my-2+r][mx-2+c];
      exp_q.push_back(w);
    end
    if (mx == W-1) begin
      mx = 0;
      if (my == H-1) begin mactive = 0; exp_done++; end
      else my++;
    end else begin
      mx++;
    end
  endtask

  task automatic send(input bit sof, input logic [DW-1:0] val, input int gap);
    repeat (gap) begin
      bus.i_pix_valid = 1'b0;
      @(posedge clk); #1;
    end
    bus.i_pix_valid = 1'b1;
    bus.i_pix_sof   = sof;
    bus.i_pix_data  = val;
    model_pixel(sof, val);
    @(posedge clk); #1;
    bus.i_pix_valid = 1'b0;
    bus.i_pix_sof   = 1'b0;
    cfg_wr          = 1'b0;
  endtask

  // First npix raster pixels of a frame; rnd selects random data, wr posts a threshold at (1,2)
  task automatic send_frame(input bit rnd, input int maxgap, input int npix,
                            input bit wr, input logic [11:0] wval);
    int n = 0;
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++) begin
        logic [DW-1:0] v;
        if (n >= npix) return;
        v = rnd ? DW'($urandom) : DW'(x + 10*y);
        if (wr && y == 2 && x == 1) begin
          cfg_thresh = wval;
          cfg_wr     = 1'b1;
        end
        send(x == 0 && y == 0, v, (maxgap > 0) ? int'($urandom_range(maxgap, 0)) : 0);
        n++;
      end
  endtask

  task automatic drain(input string nm);
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
    repeat (3) @(posedge clk);
    #1;
    chk({nm, "_pending_windows"}, exp_q.size(), 0);
    chk({nm, "_frame_done_count"}, seen_done, exp_done);
    chk({nm, "_overrun_count"}, seen_ovr, exp_ovr);
  endtask

  // Monitor: compare every presented window against the scoreboard
  always @(negedge clk) begin
    if (rstn) begin
      if (bus.o_win_valid) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL window_unexpected: got %h expected none", bus.o_win_data);
        end else begin
          logic [9*DW-1:0] e;
          e = exp_q.pop_front();
          if (bus.o_win_data !== e) begin
            errors++;
            $display("FAIL window: got %h expected %h", bus.o_win_data, e);
          end
        end
      end
      if (fdone) seen_done++;
      if (ovr)   seen_ovr++;
      if (watch_thresh && busy && !fdone && thresh !== TR) early_thresh = 1;
    end
  end

  initial begin
    bus.i_pix_valid = 1'b0;
    bus.i_pix_sof   = 1'b0;
    bus.i_pix_data  = '0;
    cfg_thresh      = '0;
    cfg_wr          = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_win_valid", bus.o_win_valid, 0);
    chk("rst_win_data_zero", (bus.o_win_data == '0), 1);
    chk("rst_thresh", thresh, TR);
    chk("rst_busy", busy, 0);
    chk("rst_frame_done", fdone, 0);
    chk("rst_overrun", ovr, 0);
    rstn = 1'b1;
    @(posedge clk); #1;

    // Non-sof pixels in IDLE are dropped
    send(0, 12'd123, 0);
    send(0, 12'd77, 1);
    chk("idle_drop_busy", busy, 0);

    // Continuous frame with a threshold write during RUN
    watch_thresh = 1;
    send_frame(0, 0, W*H, 1, 12'd50);
    drain("frame1");
    watch_thresh = 0;
    chk("thresh_stable_in_frame", early_thresh, 0);
    chk("thresh_applied_after_done", thresh, 50);

    // Same frame with random gaps
    send(1, 12'd0, 0);
    chk("busy_after_sof", busy, 1);
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++)
        if (x != 0 || y != 0) send(0, DW'(x + 10*y), int'($urandom_range(3, 0)));
    drain("frame2_gaps");
`ifdef SOBEL_WIN_STATS_EN
    chk("win_count_after_done", win_count, 6);
`endif

    // Threshold write in IDLE, then two back-to-back writes (last one wins)
    cfg_thresh = 12'd60; cfg_wr = 1'b1;
    @(posedge clk); #1; cfg_wr = 1'b0;
    @(posedge clk); #1;
    chk("thresh_idle_apply", thresh, 60);
    cfg_thresh = 12'd70; cfg_wr = 1'b1;
    @(posedge clk); #1; cfg_thresh = 12'd80;
    @(posedge clk); #1; cfg_wr = 1'b0;
    repeat (3) @(posedge clk); #1;
    chk("thresh_last_write_wins", thresh, 80);

    // Overrun: sof arrives in place of pixel (2,3)
    send_frame(1, 0, 3*W + 2, 0, '0);
`ifdef SOBEL_WIN_STATS_EN
    chk("win_count_cleared_on_sof", win_count, 3);
`endif
    send_frame(1, 2, W*H, 0, '0);
    drain("overrun");
    chk("overrun_expected_once", exp_ovr, 1);

    // Asynchronous reset while pixel (3,2) is on the bus
    send_frame(1, 0, 2*W + 3, 0, '0);
    bus.i_pix_valid = 1'b1;
    bus.i_pix_data  = 12'd32;
    @(negedge clk); #1;
    rstn = 1'b0;
    #1;
    chk("arst_win_valid", bus.o_win_valid, 0);
    chk("arst_win_data_zero", (bus.o_win_data == '0), 1);
    chk("arst_thresh", thresh, TR);
    chk("arst_busy", busy, 0);
    chk("arst_frame_done", fdone, 0);
    chk("arst_overrun", ovr, 0);
    bus.i_pix_valid = 1'b0;
    mactive = 0;
    exp_q.delete();
    @(posedge clk); #1;
    rstn = 1'b1;
    send(0, 12'd5, 0);
    send(0, 12'd6, 0);
    chk("post_reset_drop_busy", busy, 0);
    send_frame(1, 3, W*H, 0, '0);
    drain("after_reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Safety bound on total run time
  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule
